// File: rtl/alu_pkg.sv
// Shared types for the chunk-serial add/subtract unit: FSM state encoding and chunk-count helper.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_e;

  function automatic int num_chunks(input int data_size, input int chunk_size);
    return data_size / chunk_size;
  endfunction

endpackage

// File: rtl/cla_1_bit.sv
// Single-bit generate/propagate cell used to build the carry-lookahead chunk adder.
module cla_1_bit (
  input  logic a_i,
  input  logic b_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;

endmodule

// File: rtl/cla_chunk.sv
// W-bit carry-lookahead adder: every carry is a flat OR of generate terms gated by propagate runs.
module cla_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         c_msb_o,
  output logic         cout_o
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W:0]   c;
  logic         run;

  for (genvar i = 0; i < W; i++) begin : g_bit
    cla_1_bit u_bit (
      .a_i(a_i[i]),
      .b_i(b_i[i]),
      .g_o(g[i]),
      .p_o(p[i])
    );
  end

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built from g/p only so no carry ripples
  always_comb begin
    c    = '0;
    run  = 1'b0;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      c[i+1] = g[i];
      run    = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run & g[j]);
        run    = run & p[j];
      end
      c[i+1] = c[i+1] | (run & cin_i);
    end
  end

  assign sum_o   = p ^ c[W-1:0];
  assign c_msb_o = c[W-1];
  assign cout_o  = c[W];

endmodule

// File: rtl/add_sub_seq.sv
// Chunk-serial add/subtract: CHUNK_SIZE bits per clock, LSB chunk first, carry held in a register
// between chunks; signed/unsigned flags, optional saturation, valid/ready on both sides.
module add_sub_seq
  import alu_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int SATURATE   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] a1,
  input  logic [DATA_SIZE-1:0] b,
  input  logic                 cin,
  input  logic                 operation,
  input  logic                 signed_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] s,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic                 neg
);

  localparam int NC = num_chunks(DATA_SIZE, CHUNK_SIZE);
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NC - 1);

  if ((DATA_SIZE % CHUNK_SIZE) != 0 || NC < 1) begin : g_bad_params
    $error("add_sub_seq: DATA_SIZE must be a non-zero multiple of CHUNK_SIZE");
  end

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [DATA_SIZE-1:0] a_q, b_q, res_q, s_q;
  logic                 carry_q, op_q, sgn_q;
  logic                 out_valid_q, cout_q, ovf_q, zero_q, neg_q;

  logic                  accept;
  logic [CHUNK_SIZE-1:0] a_chunk, b_chunk, sum_chunk;
  logic                  c_msb, c_out, ovf_d;
  logic [DATA_SIZE-1:0]  res_d, s_d;

  function automatic logic [DATA_SIZE-1:0] sat_value(input logic sgn, input logic add,
                                                     input logic a_msb);
    if (sgn)
      return a_msb ? {1'b1, {(DATA_SIZE-1){1'b0}}} : {1'b0, {(DATA_SIZE-1){1'b1}}};
    return add ? {DATA_SIZE{1'b1}} : {DATA_SIZE{1'b0}};
  endfunction

  function automatic logic raw_ovf(input logic sgn, input logic add, input logic c_into_msb,
                                   input logic c_out_msb);
    if (sgn)
      return c_into_msb ^ c_out_msb;
    return add ? c_out_msb : ~c_out_msb;
  endfunction

  // HOLD releases in the same cycle the consumer takes the result, so back-to-back ops need no bubble
  assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    a_chunk = a_q[cnt_q*CHUNK_SIZE +: CHUNK_SIZE];
    b_chunk = b_q[cnt_q*CHUNK_SIZE +: CHUNK_SIZE];
    res_d   = res_q;
    res_d[cnt_q*CHUNK_SIZE +: CHUNK_SIZE] = sum_chunk;
    ovf_d   = raw_ovf(sgn_q, op_q, c_msb, c_out);
    s_d     = ((SATURATE != 0) && ovf_d) ? sat_value(sgn_q, op_q, a_q[DATA_SIZE-1]) : res_d;
  end

  cla_chunk #(
    .W(CHUNK_SIZE)
  ) u_chunk (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (sum_chunk),
    .c_msb_o(c_msb),
    .cout_o (c_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      case (state_q)
        CALC: begin
          res_q   <= res_d;
          carry_q <= c_out;
          if (cnt_q == LAST) begin
            s_q         <= s_d;
            cout_q      <= c_out;
            ovf_q       <= ovf_d;
            zero_q      <= (s_d == '0);
            neg_q       <= s_d[DATA_SIZE-1];
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: ;
      endcase
      // Subtraction is folded into the operand: a + ~b + cin
      if (accept) begin
        a_q     <= a1;
        b_q     <= operation ? b : ~b;
        carry_q <= cin;
        op_q    <= operation;
        sgn_q   <= signed_op;
        cnt_q   <= '0;
        state_q <= CALC;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule
